// File: rtl/kyber_parse.sv
// rtl/kyber_parse.sv - Kyber Parse rejection sampler on a 64-bit SHAKE128 word stream
// Optional rejected-candidate counter enabled by defining PARSE_REJ_CNT_EN.
module kyber_parse #(
    parameter int Q       = 3329,
    parameter int N_COEFF = 256,
    parameter int COEFF_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [63:0]        in_data,
    input  logic               in_avail,
    output logic               gimme,
    output logic [COEFF_W-1:0] coeff_out,
    output logic [7:0]         coeff_idx,
    output logic               coeff_valid,
    input  logic               coeff_ready,
    output logic               busy,
    output logic               done,
    output logic [9:0]         rej_count
);

    typedef enum logic [2:0] {IDLE, REQ, CAP, SPLIT, EMIT1, EMIT2, FIN} state_t;

    localparam logic [11:0] Q12    = 12'(Q);
    localparam logic [8:0]  N_LAST = 9'(N_COEFF);

    state_t             state;
    logic [79:0]        byte_buf;
    logic [3:0]         byte_cnt;
    logic [8:0]         acc_cnt;
    logic [COEFF_W-1:0] d2_hold;
    logic               a2_hold;

    logic [11:0] d1, d2;
    logic        a1c, a2c;
    logic        hs, after_pair, do_split;
    logic [8:0]  acc_nxt;

    always_comb begin
        d1       = {byte_buf[11:8], byte_buf[7:0]};
        d2       = {byte_buf[23:16], byte_buf[15:12]};
        a1c      = d1 < Q12;
        a2c      = d2 < Q12;
        hs       = coeff_valid & coeff_ready;
        acc_nxt  = acc_cnt + {8'd0, hs};
        // A finished emission round with bytes on hand splits the next group in the
        // same cycle, so back-to-back groups stream one coefficient per cycle.
        after_pair = hs && (acc_nxt != N_LAST) &&
                     (((state == EMIT1) && !a2_hold) || (state == EMIT2));
        do_split = (state == SPLIT) || (after_pair && (byte_cnt >= 4'd3));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            byte_buf    <= '0;
            byte_cnt    <= '0;
            acc_cnt     <= '0;
            d2_hold     <= '0;
            a2_hold     <= 1'b0;
            gimme       <= 1'b0;
            coeff_out   <= '0;
            coeff_idx   <= '0;
            coeff_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done  <= 1'b0;
            gimme <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (byte_cnt >= 4'd3) begin
                        state <= SPLIT;
                    end else if (in_avail) begin
                        gimme <= 1'b1;
                        state <= CAP;
                    end
                end
                CAP: begin
                    // show-ahead FIFO: the head word is taken on the edge that pops it
                    byte_buf <= byte_buf | ({16'd0, in_data} << {byte_cnt, 3'b000});
                    byte_cnt <= byte_cnt + 4'd8;
                    state    <= SPLIT;
                end
                SPLIT: begin
                end
                EMIT1: begin
                    if (hs) begin
                        acc_cnt <= acc_nxt;
                        if (acc_nxt == N_LAST) begin
                            coeff_valid <= 1'b0;
                            state       <= FIN;
                        end else if (a2_hold) begin
                            coeff_out <= d2_hold;
                            coeff_idx <= acc_nxt[7:0];
                            state     <= EMIT2;
                        end else if (!do_split) begin
                            coeff_valid <= 1'b0;
                            state       <= REQ;
                        end
                    end
                end
                EMIT2: begin
                    if (hs) begin
                        acc_cnt <= acc_nxt;
                        if (acc_nxt == N_LAST) begin
                            coeff_valid <= 1'b0;
                            state       <= FIN;
                        end else if (!do_split) begin
                            coeff_valid <= 1'b0;
                            state       <= REQ;
                        end
                    end
                end
                FIN: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    byte_buf <= '0;
                    byte_cnt <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (do_split) begin
                byte_buf <= byte_buf >> 24;
                byte_cnt <= byte_cnt - 4'd3;
                d2_hold  <= COEFF_W'(d2);
                a2_hold  <= a2c;
                if (a1c) begin
                    coeff_out   <= COEFF_W'(d1);
                    coeff_idx   <= acc_nxt[7:0];
                    coeff_valid <= 1'b1;
                    state       <= EMIT1;
                end else if (a2c) begin
                    coeff_out   <= COEFF_W'(d2);
                    coeff_idx   <= acc_nxt[7:0];
                    coeff_valid <= 1'b1;
                    state       <= EMIT2;
                end else begin
                    coeff_valid <= 1'b0;
                    state       <= (byte_cnt >= 4'd6) ? SPLIT : REQ;
                end
            end
        end
    end

`ifdef PARSE_REJ_CNT_EN
    logic [9:0]  rej_r;
    logic [1:0]  rej_inc;
    logic [10:0] rej_sum;

    always_comb begin
        rej_inc = {1'b0, ~a1c} + {1'b0, ~a2c};
        rej_sum = {1'b0, rej_r} + {9'd0, rej_inc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rej_r <= '0;
        end else if ((state == IDLE) && start) begin
            rej_r <= '0;
        end else if (do_split) begin
            rej_r <= rej_sum[10] ? 10'h3FF : rej_sum[9:0];
        end
    end

    assign rej_count = rej_r;
`else
    assign rej_count = '0;
`endif

endmodule
